// File: rtl/ad4008_sample_sequencer.sv
// ad4008_sample_sequencer
// Paces AD4008 conversions, averages 2^avg_log2 reader samples per batch and
// hands each average downstream on a valid/ready port. Missing reader
// responses raise timeout_err; missed cadence slots raise overrun_err.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | sequencing stopped, accumulator held clear
// S_START  | one-cycle conv_start, slot and timeout timers loaded
// S_WAIT   | waiting for the reader's new_data_flag (or timeout)
// S_OUTPUT | average presented, held until avg_ready
// S_GAP    | waiting for the slot timer before the next conversion
module ad4008_sample_sequencer #(
    parameter int ADC_WIDTH      = 16,
    parameter int PERIOD_WIDTH   = 16,
    parameter int MAX_AVG_LOG2   = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                clk,
    input  logic                                aresetn,
    input  logic                                enable,
    input  logic [PERIOD_WIDTH-1:0]             period,
    input  logic [$clog2(MAX_AVG_LOG2+1)-1:0]   avg_log2,
    output logic                                conv_start,
    input  logic                                new_data_flag,
    input  logic [ADC_WIDTH-1:0]                amplified_data,
    output logic [ADC_WIDTH-1:0]                avg_data,
    output logic                                avg_valid,
    input  logic                                avg_ready,
    output logic                                timeout_err,
    output logic                                overrun_err,
    input  logic                                clear_err,
    output logic                                busy
);

    localparam int AVG_W = $clog2(MAX_AVG_LOG2 + 1);
    localparam int AW    = ADC_WIDTH + MAX_AVG_LOG2;
    localparam int CNT_W = MAX_AVG_LOG2 + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_INIT = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_WAIT   = 3'd2,
        S_OUTPUT = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [PERIOD_WIDTH-1:0] period_q;
    logic [PERIOD_WIDTH-1:0] slot_timer;
    logic [AVG_W-1:0]        avg_log2_q;
    logic [TO_W-1:0]         to_cnt;
    logic [AW-1:0]           acc;
    logic [CNT_W-1:0]        sample_cnt;
    logic                    overrun_seen;

    logic [AVG_W-1:0]        avg_log2_sat;
    logic [PERIOD_WIDTH-1:0] period_eff;
    logic [PERIOD_WIDTH-1:0] slot_load;
    logic [CNT_W-1:0]        batch_size;
    logic                    sample_take;
    logic                    batch_full;
    logic                    timeout_hit;
    logic                    slot_expired;
    logic                    handshake;
    logic                    overrun_set;
    logic                    batch_start;

    // Derived control terms shared by the FSM and the datapath.
    // The slot timer is loaded with period-2 so that a GAP->START decision
    // taken when it reads 0 lands the next conv_start exactly period cycles
    // after the previous one; a zero seen in WAIT/OUTPUT means that slot is lost.
    always_comb begin
        avg_log2_sat = (avg_log2 > AVG_W'(MAX_AVG_LOG2)) ? AVG_W'(MAX_AVG_LOG2) : avg_log2;
        period_eff   = (period == '0) ? PERIOD_WIDTH'(1) : period;
        slot_load    = (period_q >= PERIOD_WIDTH'(2)) ? (period_q - PERIOD_WIDTH'(2)) : '0;
        batch_size   = CNT_W'(1) << avg_log2_q;
        sample_take  = (state == S_WAIT) && new_data_flag;
        batch_full   = (sample_cnt + CNT_W'(1)) == batch_size;
        timeout_hit  = (state == S_WAIT) && !new_data_flag && (to_cnt == '0);
        slot_expired = (slot_timer == '0);
        handshake    = (state == S_OUTPUT) && avg_ready;
        overrun_set  = slot_expired && ((state == S_WAIT) || (state == S_OUTPUT)) && !overrun_seen;
        batch_start  = (state_next == S_START) && (sample_cnt == '0);
    end

    // State register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (enable) state_next = S_START;
            end
            S_START: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (sample_take) begin
                    state_next = batch_full ? S_OUTPUT : S_GAP;
                end else if (timeout_hit) begin
                    state_next = S_GAP;
                end
            end
            S_OUTPUT: begin
                if (avg_ready) state_next = S_GAP;
            end
            S_GAP: begin
                if (slot_expired) state_next = enable ? S_START : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Moore outputs; the average is only driven while it is being offered.
    always_comb begin
        conv_start = (state == S_START);
        avg_valid  = (state == S_OUTPUT);
        busy       = (state != S_IDLE);
        avg_data   = '0;
        if (state == S_OUTPUT) avg_data = ADC_WIDTH'(acc >> avg_log2_q);
    end

    // Timers, batch configuration, accumulator and sticky error flags.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            period_q     <= '0;
            avg_log2_q   <= '0;
            slot_timer   <= '0;
            to_cnt       <= '0;
            acc          <= '0;
            sample_cnt   <= '0;
            overrun_seen <= 1'b0;
            timeout_err  <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            if (batch_start) begin
                period_q   <= period_eff;
                avg_log2_q <= avg_log2_sat;
            end

            if (state == S_IDLE) begin
                slot_timer <= '0;
            end else if (state == S_START) begin
                slot_timer <= slot_load;
            end else if (!slot_expired) begin
                slot_timer <= slot_timer - PERIOD_WIDTH'(1);
            end

            if (state == S_START) begin
                to_cnt <= TO_INIT;
            end else if ((state == S_WAIT) && (to_cnt != '0)) begin
                to_cnt <= to_cnt - TO_W'(1);
            end

            if ((state == S_IDLE) || handshake || timeout_hit) begin
                acc        <= '0;
                sample_cnt <= '0;
            end else if (sample_take) begin
                acc        <= acc + AW'(amplified_data);
                sample_cnt <= sample_cnt + CNT_W'(1);
            end

            if (state == S_START) begin
                overrun_seen <= 1'b0;
            end else if (overrun_set) begin
                overrun_seen <= 1'b1;
            end

            timeout_err <= clear_err ? 1'b0 : (timeout_err | timeout_hit);
            overrun_err <= clear_err ? 1'b0 : (overrun_err | overrun_set);
        end
    end

endmodule

// File: tb/tb_ad4008_sample_sequencer.sv
// Scoreboard bench for ad4008_sample_sequencer: a behavioural reader answers
// conv_start after 4 cycles from a sample queue, stimulus pushes the expected
// averages, and a negedge monitor pops and compares on every accepted output.
module tb_ad4008_sample_sequencer;

    logic        clk;
    logic        aresetn;
    logic        enable;
    logic [15:0] period;
    logic [2:0]  avg_log2;
    logic        conv_start;
    logic        new_data_flag;
    logic [15:0] amplified_data;
    logic [15:0] avg_data;
    logic        avg_valid;
    logic        avg_ready;
    logic        timeout_err;
    logic        overrun_err;
    logic        clear_err;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rdr_cnt;
    logic        rdr_on;
    logic        hold_prev = 1'b0;
    logic [15:0] hold_data = '0;

    logic [15:0] sample_q[$];
    logic [15:0] exp_q[$];
    int          cs_q[$];

    ad4008_sample_sequencer dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .enable         (enable),
        .period         (period),
        .avg_log2       (avg_log2),
        .conv_start     (conv_start),
        .new_data_flag  (new_data_flag),
        .amplified_data (amplified_data),
        .avg_data       (avg_data),
        .avg_valid      (avg_valid),
        .avg_ready      (avg_ready),
        .timeout_err    (timeout_err),
        .overrun_err    (overrun_err),
        .clear_err      (clear_err),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, longint act, longint expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_exp_empty(string nm, int maxc);
        int k = 0;
        while (exp_q.size() != 0 && k < maxc) begin
            tick(1);
            k++;
        end
        chk(nm, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_idle(string nm, int maxc);
        int k = 0;
        while (busy && k < maxc) begin
            tick(1);
            k++;
        end
        chk(nm, busy, 0);
    endtask

    task automatic wait_cs(string nm, int n, int maxc);
        int k = 0;
        while (cs_q.size() < n && k < maxc) begin
            tick(1);
            k++;
        end
        chk(nm, cs_q.size() >= n, 1);
    endtask

    task automatic wait_samples_used(string nm, int maxc);
        int k = 0;
        while (sample_q.size() != 0 && k < maxc) begin
            tick(1);
            k++;
        end
        chk(nm, sample_q.size(), 0);
    endtask

    task automatic check_spacing(string nm, int expn, int gap);
        chk({nm, "_count"}, cs_q.size(), expn);
        for (int i = 1; i < cs_q.size(); i++) chk(nm, cs_q[i] - cs_q[i-1], gap);
    endtask

    // Behavioural AD4008 reader: answers each conv_start 4 cycles later.
    initial begin
        new_data_flag  = 1'b0;
        amplified_data = '0;
        rdr_cnt        = 0;
        forever begin
            @(posedge clk);
            #1;
            new_data_flag = 1'b0;
            if (!aresetn) begin
                rdr_cnt = 0;
            end else begin
                if (rdr_cnt > 0) begin
                    rdr_cnt--;
                    if (rdr_cnt == 0) begin
                        new_data_flag = 1'b1;
                        if (sample_q.size() > 0) amplified_data = sample_q.pop_front();
                        else amplified_data = '0;
                    end
                end
                if (conv_start && rdr_on) rdr_cnt = 4;
            end
        end
    end

    // Monitor: conv_start log, hold-stability and scoreboard comparison.
    always @(negedge clk) begin
        if (aresetn) begin
            if (conv_start) cs_q.push_back(cyc);
            if (hold_prev) begin
                chk("valid_held", avg_valid, 1);
                chk("avg_hold_stable", avg_data, hold_data);
            end
            if (avg_valid && avg_ready) begin
                chk("avg_expected_present", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("avg_data", avg_data, exp_q.pop_front());
            end
            hold_prev = avg_valid && !avg_ready;
            hold_data = avg_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc;
        int c1;
        int k;

        aresetn   = 1'b0;
        enable    = 1'b0;
        period    = 16'd10;
        avg_log2  = 3'd0;
        avg_ready = 1'b1;
        clear_err = 1'b0;
        rdr_on    = 1'b1;
        tick(3);
        chk("rst_conv_start", conv_start, 0);
        chk("rst_avg_valid", avg_valid, 0);
        chk("rst_avg_data", avg_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_overrun_err", overrun_err, 0);
        aresetn = 1'b1;
        tick(3);
        chk("idle_no_start", cs_q.size(), 0);

        // Cadence: period 10, pass-through averaging.
        cs_q.delete();
        sample_q = '{16'd11, 16'd22, 16'd33, 16'd44};
        exp_q    = '{16'd11, 16'd22, 16'd33, 16'd44};
        enable = 1'b1;
        wait_exp_empty("cadence_done", 80);
        enable = 1'b0;
        wait_idle("cadence_idle", 30);
        check_spacing("cadence_spacing", 4, 10);
        chk("cadence_no_overrun", overrun_err, 0);
        chk("cadence_no_timeout", timeout_err, 0);

        // Averaging of four samples: 1001 >> 2 = 250.
        cs_q.delete();
        avg_log2 = 3'd2;
        sample_q = '{16'd100, 16'd200, 16'd300, 16'd401};
        exp_q.push_back(16'd250);
        enable = 1'b1;
        wait_exp_empty("avg4_done", 80);
        enable = 1'b0;
        wait_idle("avg4_idle", 30);
        check_spacing("avg4_spacing", 4, 10);

        // avg_log2 above the maximum saturates to 16 samples: 13600/16 = 850.
        cs_q.delete();
        avg_log2 = 3'd7;
        sample_q.delete();
        for (int i = 1; i <= 16; i++) sample_q.push_back(16'(i * 100));
        exp_q.push_back(16'd850);
        enable = 1'b1;
        wait_exp_empty("avg_sat_done", 250);
        enable = 1'b0;
        wait_idle("avg_sat_idle", 30);
        chk("avg_sat_starts", cs_q.size(), 16);

        // Backpressure and overrun.
        cs_q.delete();
        period    = 16'd8;
        avg_log2  = 3'd0;
        avg_ready = 1'b0;
        sample_q  = '{16'hABCD, 16'h1234};
        exp_q     = '{16'hABCD, 16'h1234};
        enable = 1'b1;
        k = 0;
        while (!avg_valid && k < 30) begin
            tick(1);
            k++;
        end
        chk("bp_valid_seen", avg_valid, 1);
        chk("bp_no_overrun_yet", overrun_err, 0);
        tick(20);
        chk("bp_overrun_set", overrun_err, 1);
        chk("bp_single_start", cs_q.size(), 1);
        avg_ready = 1'b1;
        acc_cyc = cyc;
        wait_cs("bp_next_start", 2, 30);
        if (cs_q.size() >= 2) chk("bp_restart_delay", cs_q[1] - acc_cyc, 2);
        enable = 1'b0;
        wait_exp_empty("bp_done", 40);
        wait_idle("bp_idle", 30);
        chk("bp_overrun_sticky", overrun_err, 1);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        chk("bp_overrun_cleared", overrun_err, 0);

        // Timeout: second conversion never answered; partial sample dropped.
        cs_q.delete();
        period   = 16'd300;
        avg_log2 = 3'd1;
        sample_q = '{16'd1000};
        enable = 1'b1;
        wait_cs("to_first_start", 1, 10);
        tick(2);
        rdr_on = 1'b0;
        wait_cs("to_second_start", 2, 400);
        c1 = (cs_q.size() >= 2) ? cs_q[1] : cyc;
        k = 0;
        while (cyc < c1 + 256 && k < 400) begin
            tick(1);
            k++;
        end
        chk("to_not_yet", timeout_err, 0);
        tick(1);
        chk("to_set", timeout_err, 1);
        chk("to_no_overrun", overrun_err, 0);
        rdr_on = 1'b1;
        sample_q = '{16'd10, 16'd20};
        exp_q.push_back(16'd15);
        wait_exp_empty("to_recover_done", 700);
        enable = 1'b0;
        wait_idle("to_idle", 400);
        chk("to_sticky", timeout_err, 1);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        chk("to_cleared", timeout_err, 0);

        // Disable mid-batch discards the partial accumulation.
        cs_q.delete();
        period   = 16'd10;
        avg_log2 = 3'd2;
        sample_q = '{16'd1, 16'd2};
        enable = 1'b1;
        wait_samples_used("dis_two_samples", 40);
        enable = 1'b0;
        wait_idle("dis_idle", 40);
        chk("dis_busy", busy, 0);
        chk("dis_start_count", cs_q.size(), 2);
        chk("dis_no_valid", avg_valid, 0);
        sample_q = '{16'd40, 16'd40, 16'd40, 16'd44};
        exp_q.push_back(16'd41);
        enable = 1'b1;
        wait_exp_empty("dis_fresh_batch", 80);
        enable = 1'b0;
        wait_idle("dis_fresh_idle", 30);

        // Reset in the middle of WAIT.
        cs_q.delete();
        rdr_on   = 1'b0;
        avg_log2 = 3'd0;
        enable   = 1'b1;
        wait_cs("rst_mid_start", 1, 10);
        tick(2);
        chk("rst_mid_busy_before", busy, 1);
        aresetn = 1'b0;
        enable  = 1'b0;
        #1;
        chk("rst_mid_conv_start", conv_start, 0);
        chk("rst_mid_avg_valid", avg_valid, 0);
        chk("rst_mid_avg_data", avg_data, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_timeout_err", timeout_err, 0);
        chk("rst_mid_overrun_err", overrun_err, 0);
        tick(3);
        aresetn = 1'b1;
        cs_q.delete();
        tick(10);
        chk("rst_mid_no_start", cs_q.size(), 0);
        chk("rst_mid_idle", busy, 0);
        rdr_on   = 1'b1;
        sample_q = '{16'd77};
        exp_q.push_back(16'd77);
        enable = 1'b1;
        wait_exp_empty("rst_mid_resume", 30);
        enable = 1'b0;
        wait_idle("rst_mid_resume_idle", 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
